// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC, 1-cycle imem reads, 2-entry output FIFO, redirect and HALT handling.
// Optional perf counters (fetch_cnt, stall_cnt) are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
  parameter int         des      = 4,
  parameter int         source1  = 4,
  parameter int         source2  = 4,
  parameter int         total_in = 4 + des + source1 + source2,
  parameter int         pc_w     = 8,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [pc_w-1:0]     start_pc,
  input  logic                redirect,
  input  logic [pc_w-1:0]     redirect_pc,
  output logic                imem_rd_en,
  output logic [pc_w-1:0]     imem_addr,
  input  logic [total_in-1:0] imem_data,
  output logic                ins_valid,
  input  logic                ins_ready,
  output logic [total_in-1:0] ins_out,
  output logic [pc_w-1:0]     ins_pc,
  output logic                halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         fetch_cnt,
  output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t state, state_next;

  logic [pc_w-1:0]     pc;
  logic                inflight;
  logic [pc_w-1:0]     inflight_pc;
  logic [total_in-1:0] buf_ins [2];
  logic [pc_w-1:0]     buf_pc  [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count;

  logic start_ok, issue, accept, halt_hit;

  always_comb begin
    start_ok   = start && (state != RUN);
    // Pop of this cycle is not credited: keeps ins_ready off the memory request path.
    issue      = (state == RUN) && ((count + {1'b0, inflight}) < 2'd2);
    accept     = (count != 2'd0) && ins_ready;
    halt_hit   = (state == RUN) && inflight && (imem_data[total_in-1 -: 4] == HALT_OP);
    state_next = state;
    if (redirect)      state_next = RUN;
    else if (start_ok) state_next = RUN;
    else if (halt_hit) state_next = HALTED;
  end

  assign imem_rd_en = issue;
  assign imem_addr  = pc;
  assign ins_valid  = (count != 2'd0);
  assign ins_out    = buf_ins[rd_ptr];
  assign ins_pc     = buf_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      halted      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_ins[i] <= '0;
        buf_pc[i]  <= '0;
      end
    end else if (redirect) begin
      // Flush everything; a read issued this cycle is dropped via the cleared in-flight flag.
      pc       <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      halted   <= 1'b0;
    end else begin
      if (start_ok) begin
        pc     <= start_pc;
        halted <= 1'b0;
      end else if (issue) begin
        pc <= pc + 1'b1;
      end
      if (halt_hit) halted <= 1'b1;
      // The read issued alongside a returning HALT word is discarded.
      inflight <= issue && !halt_hit;
      if (issue) inflight_pc <= pc;
      if (inflight) begin
        buf_ins[wr_ptr] <= imem_data;
        buf_pc[wr_ptr]  <= inflight_pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (accept) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, accept};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (start_ok) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (fetch_cnt != 16'hFFFF)) fetch_cnt <= fetch_cnt + 16'd1;
      if (ins_valid && !ins_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
